stage_ex_md: RTL
================

# stage_ex_md

Parametrised execute stage for the pipelined core: operand forwarding from EX/MM, an extended single-cycle ALU, branch/jump resolution, and an iterative multi-cycle multiply/divide unit that holds the pipeline with `busy` until its result is ready. It sits between the ID and MM stages and drives the EX/MM pipeline registers and the fetch redirect.

## Interface
- `DATA_W`, 32: datapath and operand width; must be ≥ 8 and even.
- `INST_ADDR_W`, 32: PC width; must be ≤ `DATA_W`.
- `REG_ADDR_W`, 5: register-index width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en`, `stall` in 1 each: register update enable, and downstream stall.
- `flush` in 1: the EX instruction is a bubble.
- `pc` in `INST_ADDR_W`: PC of the EX instruction.
- `reg_wr` in 1; `reg_addr_rd`, `reg_addr_r1`, `reg_addr_r2` in `REG_ADDR_W` each.
- `alu_op` in 4: ADD=0, SUB=1, AND=2, XOR=3, OR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.
- `alu_src_arg1`, `alu_src_arg2` in `ALU_SRC_W` each: operand selects, using the `ALU_SRC_PC` and `ALU_SRC_IMM` encodings.
- `imm`, `reg_data_r1`, `reg_data_r2` in `DATA_W` each.
- `is_jump`, `is_branch` in 1 each; `branch_type` in 3: RISC-V func3 encoding.
- `is_muldiv` in 1; `muldiv_op` in 3: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
- `ffw_EX_reg_wr`, `ffw_EX_reg_addr_rd`, `ffw_EX_reg_data_rd` in: forwarding from EX/MM.
- `ffw_MM_reg_wr`, `ffw_MM_reg_addr_rd`, `ffw_MM_reg_data_rd` in: forwarding from MM/WB.
- `jump` out 1; `jump_addr` out `INST_ADDR_W`: redirect request and target (ALU result, truncated).
- `busy` out 1: multi-cycle operation pending; ID must hold all inputs stable and not advance.
- `out_reg_wr` out 1; `out_reg_addr_rd` out `REG_ADDR_W`; `out_reg_data_rd` out `DATA_W`; `out_flush` out 1.

## Operation
- Forwarding priority per operand: EX match, then MM match, then the register file value. Register 0 is forwarded like any other register; ID guarantees that r0 is never written.
- PC is zero-extended to `DATA_W`. Shifts use `arg2[$clog2(DATA_W)-1:0]`. SLT/SLTU produce 0 or 1, zero-extended. Undefined `alu_op` produces 0.
- Branch conditions use the forwarded operands. `jump = (is_jump | (is_branch & cond)) & !flush & !busy`.
- Non-muldiv writeback data: `pc+4` when `is_jump`, otherwise the ALU result.
- **Muldiv FSM states.**
  - IDLE → RUN when `en & !flush & is_muldiv` and the configuration macro is defined. The forwarded operands and `muldiv_op` are latched; the counter is loaded with `DATA_W`.
  - RUN: one shift-add or restoring-subtract iteration per cycle on the magnitudes. Signed ops convert the operands to magnitudes at latch time and fix the sign at completion. RUN → DONE when the counter reaches 0.
  - DONE: holds the result until `en & !stall`, then moves to IDLE in the same edge that loads the output registers.
  - `flush` asserted in RUN or DONE → IDLE with no writeback.
  - `rst` in any state → IDLE.
- `busy = (state==IDLE & en & !flush & is_muldiv) | state==RUN`. This is combinational from the inputs in IDLE.
- Output registers update on `en & !stall & !busy`:
  - `out_reg_wr <= reg_wr & !flush`
  - `out_flush <= flush`
  - the muldiv result when in DONE
- Divide boundary cases:
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Signed overflow (most-negative / −1): quotient = dividend, remainder = 0.
- MUL returns the low `DATA_W` bits; MULH, MULHSU and MULHU return the high `DATA_W` bits.

## Timing
- Reset values: `out_reg_wr`=0, `out_reg_addr_rd`=0, `out_reg_data_rd`=0, `out_flush`=1, state=IDLE, `busy`=0.
- Non-muldiv latency: 1 cycle, from inputs to the output registers.
- Muldiv issue cycle T: `busy`=1.
  - Cycles T+1 … T+`DATA_W`: state RUN, `busy`=1.
  - Cycle T+`DATA_W`+1: state DONE, `busy`=0.
  - The result registers at the end of that cycle if `!stall`. Total occupancy is `DATA_W`+2 cycles.
- `stall` in DONE: state DONE is held and `busy` stays 0; the output registers are held.
- `en`=0 in RUN: iterations continue.
- `jump` and `jump_addr` are combinational in the same cycle.

## Configuration
- `STAGE_EX_MULDIV_EN`, defined: the FSM, datapath and `busy` are present as described above.
- `STAGE_EX_MULDIV_EN`, undefined: no FSM is built and `busy` is tied to 0. An instruction with `is_muldiv`=1 completes in 1 cycle with `out_reg_wr`=0 and `out_reg_data_rd`=0, i.e. it behaves as a NOP.

## Test plan
1. ADD with EX forward.
   - Stimulus: `reg_data_r1`=5, EX forwarding x3=100 with `reg_addr_r1`=3, `alu_op`=ADD, imm=7.
   - Response: after 1 cycle, `out_reg_data_rd`=107, `out_reg_wr`=1. With both EX and MM matching, the EX value is used.
2. BLT, signed compare.
   - Stimulus: r1=0xFFFFFFFF, r2=1, `branch_type`=BLT, `is_branch`=1, `pc`=0x100, imm=0x20.
   - Response: `jump`=1, `jump_addr`=0x120 in the same cycle. With `flush`=1, `jump`=0.
3. DIVU timing.
   - Stimulus: DIVU 100/7.
   - Response: `busy` high for 33 cycles, then `out_reg_data_rd`=14. REMU with the same operands gives 2.
4. Signed divide edge cases.
   - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0.
   - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
5. Signed multiply.
   - MULH 0xFFFFFFFF × 0xFFFFFFFF → 0; MUL of the same → 1.
   - MULHU 0xFFFFFFFF × 2 → 1.
6. Abort and hold.
   - `flush` at RUN cycle 10 → IDLE, `busy`=0, `out_reg_wr`=0.
   - `rst` mid-RUN → all reset values.
   - `stall` held 3 cycles in DONE → result registers on the first cycle with `stall`=0.

Source files
------------

// File: rtl/stage_ex_md.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and, when
// STAGE_EX_MULDIV_EN is defined, an iterative multiply/divide unit that holds ID via busy.
module stage_ex_md #(
  parameter int                   DATA_W      = 32,
  parameter int                   INST_ADDR_W = 32,
  parameter int                   REG_ADDR_W  = 5,
  parameter int                   ALU_SRC_W   = 2,
  parameter logic [ALU_SRC_W-1:0] ALU_SRC_PC  = ALU_SRC_W'(1),
  parameter logic [ALU_SRC_W-1:0] ALU_SRC_IMM = ALU_SRC_W'(2)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [INST_ADDR_W-1:0] pc,
  input  logic                   reg_wr,
  input  logic [REG_ADDR_W-1:0]  reg_addr_rd,
  input  logic [REG_ADDR_W-1:0]  reg_addr_r1,
  input  logic [REG_ADDR_W-1:0]  reg_addr_r2,
  input  logic [3:0]             alu_op,
  input  logic [ALU_SRC_W-1:0]   alu_src_arg1,
  input  logic [ALU_SRC_W-1:0]   alu_src_arg2,
  input  logic [DATA_W-1:0]      imm,
  input  logic [DATA_W-1:0]      reg_data_r1,
  input  logic [DATA_W-1:0]      reg_data_r2,
  input  logic                   is_jump,
  input  logic                   is_branch,
  input  logic [2:0]             branch_type,
  input  logic                   is_muldiv,
  input  logic [2:0]             muldiv_op,
  input  logic                   ffw_EX_reg_wr,
  input  logic [REG_ADDR_W-1:0]  ffw_EX_reg_addr_rd,
  input  logic [DATA_W-1:0]      ffw_EX_reg_data_rd,
  input  logic                   ffw_MM_reg_wr,
  input  logic [REG_ADDR_W-1:0]  ffw_MM_reg_addr_rd,
  input  logic [DATA_W-1:0]      ffw_MM_reg_data_rd,
  output logic                   jump,
  output logic [INST_ADDR_W-1:0] jump_addr,
  output logic                   busy,
  output logic                   out_reg_wr,
  output logic [REG_ADDR_W-1:0]  out_reg_addr_rd,
  output logic [DATA_W-1:0]      out_reg_data_rd,
  output logic                   out_flush
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0] op1, op2, arg1, arg2, alu_res, pc_ext, wb_data;
  logic              cond;
  logic              md_take, md_nop;
  logic [DATA_W-1:0] md_res;

  // EX/MM is younger than MM/WB, so it wins when both match
  always_comb begin
    op1 = reg_data_r1;
    if (ffw_EX_reg_wr && ffw_EX_reg_addr_rd == reg_addr_r1)      op1 = ffw_EX_reg_data_rd;
    else if (ffw_MM_reg_wr && ffw_MM_reg_addr_rd == reg_addr_r1) op1 = ffw_MM_reg_data_rd;
    op2 = reg_data_r2;
    if (ffw_EX_reg_wr && ffw_EX_reg_addr_rd == reg_addr_r2)      op2 = ffw_EX_reg_data_rd;
    else if (ffw_MM_reg_wr && ffw_MM_reg_addr_rd == reg_addr_r2) op2 = ffw_MM_reg_data_rd;
  end

  assign pc_ext = DATA_W'(pc);

  always_comb begin
    arg1 = op1;
    if (alu_src_arg1 == ALU_SRC_PC)       arg1 = pc_ext;
    else if (alu_src_arg1 == ALU_SRC_IMM) arg1 = imm;
    arg2 = op2;
    if (alu_src_arg2 == ALU_SRC_PC)       arg2 = pc_ext;
    else if (alu_src_arg2 == ALU_SRC_IMM) arg2 = imm;
  end

  always_comb begin
    alu_res = '0;
    case (alu_op)
      4'd0: alu_res = arg1 + arg2;
      4'd1: alu_res = arg1 - arg2;
      4'd2: alu_res = arg1 & arg2;
      4'd3: alu_res = arg1 ^ arg2;
      4'd4: alu_res = arg1 | arg2;
      4'd5: alu_res = arg1 << arg2[SH_W-1:0];
      4'd6: alu_res = arg1 >> arg2[SH_W-1:0];
      4'd7: alu_res = $unsigned($signed(arg1) >>> arg2[SH_W-1:0]);
      4'd8: alu_res = DATA_W'($signed(arg1) < $signed(arg2));
      4'd9: alu_res = DATA_W'(arg1 < arg2);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    cond = 1'b0;
    case (branch_type)
      3'd0: cond = (op1 == op2);
      3'd1: cond = (op1 != op2);
      3'd4: cond = ($signed(op1) <  $signed(op2));
      3'd5: cond = ($signed(op1) >= $signed(op2));
      3'd6: cond = (op1 <  op2);
      3'd7: cond = (op1 >= op2);
      default: cond = 1'b0;
    endcase
  end

  assign jump      = (is_jump | (is_branch & cond)) & ~flush & ~busy;
  assign jump_addr = alu_res[INST_ADDR_W-1:0];
  assign wb_data   = is_jump ? pc_ext + DATA_W'(4) : alu_res;

`ifdef STAGE_EX_MULDIV_EN
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} md_state_t;

  // Per-operation context captured at issue; acc carries the evolving magnitudes
  typedef struct packed {
    logic [2:0]        op;
    logic              neg_q;
    logic              neg_r;
    logic              divz;
    logic              ovf;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } md_ctx_t;

  md_state_t           state, state_nxt;
  md_ctx_t             ctx;
  logic [2*DATA_W-1:0] acc, prod;
  logic [CNT_W-1:0]    cnt;
  logic                issue, a_sgn, b_sgn, a_neg, b_neg;
  logic [DATA_W-1:0]   a_mag, b_mag, quo, rem;
  logic [DATA_W:0]     mul_sum, div_rem, div_diff;

  assign issue   = (state == S_IDLE) & en & ~flush & is_muldiv;
  assign busy    = issue | (state == S_RUN);
  assign md_take = (state == S_DONE) & ~flush;
  assign md_nop  = 1'b0;

  always_comb begin
    a_sgn = (muldiv_op == 3'd1) | (muldiv_op == 3'd2) | (muldiv_op == 3'd4) | (muldiv_op == 3'd6);
    b_sgn = (muldiv_op == 3'd1) | (muldiv_op == 3'd4) | (muldiv_op == 3'd6);
    a_neg = a_sgn & op1[DATA_W-1];
    b_neg = b_sgn & op2[DATA_W-1];
    a_mag = a_neg ? -op1 : op1;
    b_mag = b_neg ? -op2 : op2;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (issue) state_nxt = S_RUN;
      S_RUN: begin
        if (flush)                   state_nxt = S_IDLE;
        else if (cnt == CNT_W'(1))   state_nxt = S_DONE;  // last iteration
      end
      S_DONE: if (flush | (en & ~stall)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // acc = {hi, lo}: multiply shifts the product in from the top while consuming
  // the multiplier from lo; divide shifts the dividend out of lo into the remainder.
  always_comb begin
    mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, ctx.b} : '0);
    div_rem  = acc[2*DATA_W-1:DATA_W-1];
    div_diff = div_rem - {1'b0, ctx.b};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctx <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (issue) begin
      ctx.op    <= muldiv_op;
      ctx.neg_q <= a_neg ^ b_neg;
      ctx.neg_r <= a_neg;
      ctx.divz  <= (op2 == '0);
      ctx.ovf   <= muldiv_op[2] & b_sgn & (op1 == {1'b1, {(DATA_W-1){1'b0}}}) & (&op2);
      ctx.a     <= op1;
      ctx.b     <= b_mag;
      acc       <= {{DATA_W{1'b0}}, a_mag};
      cnt       <= CNT_W'(DATA_W);
    end else if (state == S_RUN) begin
      cnt <= cnt - CNT_W'(1);
      if (!ctx.op[2])         acc <= {mul_sum, acc[DATA_W-1:1]};
      else if (!div_diff[DATA_W]) acc <= {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
      else                    acc <= {div_rem[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
    end
  end

  always_comb begin
    prod   = ctx.neg_q ? -acc : acc;
    quo    = ctx.neg_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
    rem    = ctx.neg_r ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
    md_res = '0;
    case (ctx.op)
      3'd0:             md_res = prod[DATA_W-1:0];
      3'd1, 3'd2, 3'd3: md_res = prod[2*DATA_W-1:DATA_W];
      3'd4, 3'd5:       md_res = ctx.divz ? '1 : (ctx.ovf ? ctx.a : quo);
      default:          md_res = ctx.divz ? ctx.a : (ctx.ovf ? '0 : rem);
    endcase
  end
`else
  // Without the unit a muldiv instruction retires as a NOP
  logic md_unused;
  assign md_unused = ^muldiv_op;
  assign busy      = 1'b0;
  assign md_take   = 1'b0;
  assign md_nop    = is_muldiv;
  assign md_res    = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg_wr      <= 1'b0;
      out_reg_addr_rd <= '0;
      out_reg_data_rd <= '0;
      out_flush       <= 1'b1;
    end else if (en & ~stall & ~busy) begin
      out_reg_wr      <= reg_wr & ~flush & ~md_nop;
      out_reg_addr_rd <= reg_addr_rd;
      out_reg_data_rd <= md_take ? md_res : (md_nop ? '0 : wb_data);
      out_flush       <= flush;
    end
  end

endmodule
